// File: rtl/decode_pkg.sv
// Shared types and helpers for the registered 16-bit decode stage.
package decode_pkg;

    localparam int CTRL_PC_W = 8;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_B   = 3'b010;
    localparam logic [2:0] OP_LDR = 3'b011;
    localparam logic [2:0] OP_STR = 3'b100;
    localparam logic [2:0] OP_ALU = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam logic [1:0] B_BX  = 2'b00;
    localparam logic [1:0] B_RSV = 2'b01;
    localparam logic [1:0] B_BLX = 2'b10;
    localparam logic [1:0] B_BL  = 2'b11;

    localparam int T_ALU  = 0;
    localparam int T_LDR  = 1;
    localparam int T_STR  = 2;
    localparam int T_BL   = 3;
    localparam int T_BX   = 4;
    localparam int T_BLX  = 5;
    localparam int T_BRSV = 6;

    localparam int U_RD = 0;
    localparam int U_RN = 1;
    localparam int U_RM = 2;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [CTRL_PC_W-1:0] pc;
        logic                 asel;
        logic                 bsel;
        logic                 loads;
        logic [1:0]           aluop;
        logic [1:0]           shift;
        logic                 write;
        logic [2:0]           writenum;
    } ctrl_t;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_sb_comb.sv
// Pure combinational decoder: one 16-bit instruction to control,
// register numbers, read flags, one-hot type and 16-bit immediate.
module decode_comb
    import decode_pkg::*;
(
    input  logic [15:0]          ir,
    input  logic [CTRL_PC_W-1:0] pc,
    output ctrl_t                ctrl,
    output logic [2:0]           rm,
    output logic [2:0]           rn,
    output logic [2:0]           rd,
    output logic [2:0]           used,
    output logic [6:0]           typ,
    output logic [15:0]          imm
);

    logic [2:0] op;
    logic [1:0] sub;

    assign op  = ir[15:13];
    assign sub = ir[12:11];

    always_comb begin
        ctrl        = '0;
        ctrl.opcode = op;
        ctrl.pc     = pc;
        rm          = '0;
        rn          = '0;
        rd          = ir[7:5];
        used        = '0;
        typ         = '0;
        imm         = '0;
        unique case (op)
            OP_NOP: begin
            end
            OP_MOV: begin
                ctrl.write = 1'b1;
                ctrl.bsel  = 1'b1;
                if (sub == 2'b10) begin
                    ctrl.asel     = 1'b1;
                    ctrl.writenum = ir[10:8];
                    imm           = sext8(ir[7:0]);
                end else begin
                    ctrl.writenum = ir[7:5];
                    ctrl.shift    = ir[4:3];
                    rm            = ir[2:0];
                    used          = 3'b100;
                end
            end
            OP_ALU: begin
                ctrl.aluop = sub;
                ctrl.shift = ir[4:3];
                rn         = ir[10:8];
                rm         = ir[2:0];
                typ[T_ALU] = 1'b1;
                unique case (sub)
                    ALU_CMP: begin
                        ctrl.loads = 1'b1;
                        used       = 3'b110;
                    end
                    ALU_MVN: begin
                        ctrl.write    = 1'b1;
                        ctrl.writenum = ir[7:5];
                        used          = 3'b100;
                    end
                    default: begin
                        ctrl.write    = 1'b1;
                        ctrl.writenum = ir[7:5];
                        used          = 3'b110;
                    end
                endcase
            end
            OP_STR: begin
                ctrl.bsel  = 1'b1;
                rm         = ir[10:8];
                imm        = sext5(ir[4:0]);
                used       = 3'b101;
                typ[T_STR] = 1'b1;
            end
            OP_LDR: begin
                ctrl.bsel     = 1'b1;
                ctrl.write    = 1'b1;
                ctrl.writenum = ir[7:5];
                rm            = ir[10:8];
                imm           = sext5(ir[4:0]);
                used          = 3'b100;
                typ[T_LDR]    = 1'b1;
            end
            OP_B: begin
                unique case (sub)
                    B_BL: begin
                        ctrl.write    = 1'b1;
                        ctrl.writenum = 3'd7;
                        imm           = sext8(ir[7:0]);
                        typ[T_BL]     = 1'b1;
                    end
                    B_BX: begin
                        used      = 3'b001;
                        typ[T_BX] = 1'b1;
                    end
                    B_BLX: begin
                        ctrl.write    = 1'b1;
                        ctrl.writenum = 3'd7;
                        used          = 3'b001;
                        typ[T_BLX]    = 1'b1;
                    end
                    default: typ[T_BRSV] = 1'b1;
                endcase
            end
            default: typ[T_BRSV] = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage_sb.sv
// Registered decode stage with valid/ready handshake, per-register
// in-flight write scoreboard and a saturating stall counter.
module decode_stage_sb
    import decode_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int PC_W         = 8,
    parameter int NREG         = 8,
    parameter int MAX_INFLIGHT = 3,
    parameter int FWD_ALU      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_ir,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output ctrl_t             out_ctrl,
    output logic [2:0]        out_rm,
    output logic [2:0]        out_rn,
    output logic [2:0]        out_rd,
    output logic [2:0]        out_used,
    output logic [6:0]        out_type,
    output logic [DATA_W-1:0] out_sximm,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic [2:0]        wb_num,
    input  logic              wb_is_load,
    output logic [31:0]       stall_cnt
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

    ctrl_t       dec_ctrl;
    logic [2:0]  dec_rm, dec_rn, dec_rd, dec_used;
    logic [6:0]  dec_type;
    logic [15:0] dec_imm;

    decode_comb u_dec (
        .ir   (in_ir),
        .pc   (CTRL_PC_W'(in_pc)),
        .ctrl (dec_ctrl),
        .rm   (dec_rm),
        .rn   (dec_rn),
        .rd   (dec_rd),
        .used (dec_used),
        .typ  (dec_type),
        .imm  (dec_imm)
    );

    logic              out_valid_q, out_valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [2:0]        rm_q, rm_d, rn_q, rn_d, rd_q, rd_d;
    logic [2:0]        used_q, used_d;
    logic [6:0]        type_q, type_d;
    logic [DATA_W-1:0] sximm_q, sximm_d;
    logic [31:0]       stall_q, stall_d;
    logic [CW-1:0]     wr_cnt_q [NREG];
    logic [CW-1:0]     wr_cnt_d [NREG];
    logic [CW-1:0]     ld_cnt_q [NREG];
    logic [CW-1:0]     ld_cnt_d [NREG];
    logic [CW-1:0]     pend     [NREG];

    logic raw, waw_full, hazard;
    logic in_fire, out_fire;
    logic kill_w, kill_l, underflow;

    // With ALU bypass only outstanding loads block a reader.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pend[r] = (FWD_ALU != 0) ? ld_cnt_q[r] : wr_cnt_q[r];
        end
    end

    assign raw = (dec_used[U_RM] && pend[dec_rm] != '0)
              || (dec_used[U_RN] && pend[dec_rn] != '0)
              || (dec_used[U_RD] && pend[dec_rd] != '0);
    assign waw_full = dec_ctrl.write
                   && wr_cnt_q[dec_ctrl.writenum] == CNT_MAX;
    assign hazard   = raw || waw_full;
    assign in_ready = !rst && !flush && !hazard
                   && (!out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;
    assign kill_w   = flush && out_valid_q && ctrl_q.write;
    assign kill_l   = kill_w && type_q[T_LDR];

    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        rm_d        = rm_q;
        rn_d        = rn_q;
        rd_d        = rd_q;
        used_d      = used_q;
        type_d      = type_q;
        sximm_d     = sximm_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_fire) begin
            out_valid_d = 1'b1;
            ctrl_d      = dec_ctrl;
            rm_d        = dec_rm;
            rn_d        = dec_rn;
            rd_d        = dec_rd;
            used_d      = dec_used;
            type_d      = dec_type;
            sximm_d     = DATA_W'($signed(dec_imm));
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // A flushed bundle never retires, so its claim is released here.
    always_comb begin
        int ws;
        int ls;
        ws        = 0;
        ls        = 0;
        underflow = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            ws = int'(wr_cnt_q[r])
               + int'(in_fire && dec_ctrl.write
                      && dec_ctrl.writenum == 3'(r))
               - int'(wb_valid && wb_num == 3'(r))
               - int'(kill_w && ctrl_q.writenum == 3'(r));
            ls = int'(ld_cnt_q[r])
               + int'(in_fire && dec_type[T_LDR]
                      && dec_ctrl.writenum == 3'(r))
               - int'(wb_valid && wb_is_load && wb_num == 3'(r))
               - int'(kill_l && ctrl_q.writenum == 3'(r));
            if (ws < 0 || ls < 0) underflow = 1'b1;
            wr_cnt_d[r] = (ws < 0) ? '0 : CW'(ws);
            ld_cnt_d[r] = (ls < 0) ? '0 : CW'(ls);
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (in_valid && !in_ready && !flush && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            rm_q        <= '0;
            rn_q        <= '0;
            rd_q        <= '0;
            used_q      <= '0;
            type_q      <= '0;
            sximm_q     <= '0;
            stall_q     <= '0;
            for (int r = 0; r < NREG; r++) begin
                wr_cnt_q[r] <= '0;
                ld_cnt_q[r] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            rm_q        <= rm_d;
            rn_q        <= rn_d;
            rd_q        <= rd_d;
            used_q      <= used_d;
            type_q      <= type_d;
            sximm_q     <= sximm_d;
            stall_q     <= stall_d;
            wr_cnt_q    <= wr_cnt_d;
            ld_cnt_q    <= ld_cnt_d;
        end
    end

    a_no_underflow: assert property (
        @(posedge clk) disable iff (rst) !underflow
    );

    assign out_valid = out_valid_q;
    assign out_ctrl  = ctrl_q;
    assign out_rm    = rm_q;
    assign out_rn    = rn_q;
    assign out_rd    = rd_q;
    assign out_used  = used_q;
    assign out_type  = type_q;
    assign out_sximm = sximm_q;
    assign stall_cnt = stall_q;

endmodule
